// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: word alignment via bitslip, control-token detection,
// 8b data decode and lock supervision for one channel of a DVI receiver.
module tmds_channel_decoder #(
    parameter int CTRL_RUN  = 8,     // consecutive control tokens needed for lock
    parameter int TIMEOUT   = 2048,  // valid symbols without a token before slip/unlock
    parameter int SLIP_WAIT = 4      // valid symbols discarded after a bitslip (>= 1)
) (
    input  logic       clk_pixel,
    input  logic       rst_n,
    input  logic [9:0] symbol_in,
    input  logic       symbol_valid,
    output logic       bitslip,
    output logic       locked,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       vld_out,
    output logic       sym_err
);

    localparam int GAP_W = $clog2(TIMEOUT + 1);
    localparam int RUN_W = $clog2(CTRL_RUN + 1);
    localparam int SET_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e             state_q;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [SET_W-1:0]   settle_q;
    logic               locked_q;
    logic               bitslip_q;
    logic               sym_err_q;

    logic [7:0]         data_q;
    logic [1:0]         ctrl_q;
    logic               de_q;
    logic               vld_q;

    logic               is_ctrl;
    logic [1:0]         ctrl_bits;
    logic [7:0]         d_word;
    logic [7:0]         dec_byte;

    // Classify the incoming symbol as one of the four control tokens or data.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no latch is inferred.
        is_ctrl   = 1'b1;
        ctrl_bits = 2'b00;
        case (symbol_in)
            10'h354: ctrl_bits = 2'b00;
            10'h0AB: ctrl_bits = 2'b01;
            10'h154: ctrl_bits = 2'b10;
            10'h2AB: ctrl_bits = 2'b11;
            default: is_ctrl   = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        d_word        = symbol_in[9] ? ~symbol_in[7:0] : symbol_in[7:0];
        dec_byte[0]   = d_word[0];
        dec_byte[7:1] = symbol_in[8] ?  (d_word[7:1] ^ d_word[6:0])
                                     : ~(d_word[7:1] ^ d_word[6:0]);
    end

    // Next values of the token-run and token-gap counters for the current symbol.
    always_comb begin
        run_d = '0;
        gap_d = gap_q + GAP_W'(1);
        if (is_ctrl) begin
            gap_d = '0;
            run_d = (run_q == RUN_W'(CTRL_RUN)) ? run_q : run_q + RUN_W'(1);
        end
    end

    // Alignment FSM: search for token runs, slip on timeout, supervise lock.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_SEARCH;
            run_q     <= '0;
            gap_q     <= '0;
            settle_q  <= '0;
            locked_q  <= 1'b0;
            bitslip_q <= 1'b0;
            sym_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from
            // the pre-edge values, whatever the statement order below.
            bitslip_q <= 1'b0;
            sym_err_q <= 1'b0;
            if (symbol_valid) begin
                case (state_q)
                    ST_SEARCH: begin
                        run_q <= run_d;
                        gap_q <= gap_d;
                        if (run_d == RUN_W'(CTRL_RUN)) begin
                            state_q  <= ST_LOCKED;
                            locked_q <= 1'b1;
                        end else if (gap_d == GAP_W'(TIMEOUT)) begin
                            state_q   <= ST_SETTLE;
                            bitslip_q <= 1'b1;
                            run_q     <= '0;
                            gap_q     <= '0;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q == SET_W'(SLIP_WAIT - 1)) begin
                            settle_q <= '0;
                            state_q  <= ST_SEARCH;
                        end else begin
                            settle_q <= settle_q + SET_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Compare before incrementing so the gap counter never wraps.
                        if (!is_ctrl && gap_q == GAP_W'(TIMEOUT - 1)) begin
                            state_q   <= ST_SETTLE;
                            locked_q  <= 1'b0;
                            bitslip_q <= 1'b1;
                            sym_err_q <= 1'b1;
                            run_q     <= '0;
                            gap_q     <= '0;
                        end else begin
                            gap_q <= gap_d;
                        end
                    end
                    default: state_q <= ST_SEARCH;
                endcase
            end
        end
    end

    // Decoded output register; fields hold unless a symbol arrives while locked.
    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= symbol_valid & locked_q;
            if (symbol_valid && locked_q) begin
                de_q <= ~is_ctrl;
                if (is_ctrl) begin
                    ctrl_q <= ctrl_bits;
                end else begin
                    data_q <= dec_byte;
                end
            end
        end
    end

    assign bitslip  = bitslip_q;
    assign locked   = locked_q;
    assign sym_err  = sym_err_q;
    assign data_out = data_q;
    assign ctrl_out = ctrl_q;
    assign de_out   = de_q;
    assign vld_out  = vld_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Randomised bench for tmds_channel_decoder against a behavioural model that
// decodes by searching the forward TMDS encoder and tracks lock as plain counts.
module tb_tmds_channel_decoder;

    localparam int C_RUN = 8;
    localparam int T_OUT = 64;
    localparam int S_WT  = 4;

    logic       clk_pixel = 1'b0;
    logic       rst_n     = 1'b0;
    logic [9:0] symbol_in = '0;
    logic       symbol_valid = 1'b0;
    logic       bitslip, locked, de_out, vld_out, sym_err;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;

    tmds_channel_decoder #(.CTRL_RUN(C_RUN), .TIMEOUT(T_OUT), .SLIP_WAIT(S_WT)) dut (
        .clk_pixel    (clk_pixel),
        .rst_n        (rst_n),
        .symbol_in    (symbol_in),
        .symbol_valid (symbol_valid),
        .bitslip      (bitslip),
        .locked       (locked),
        .data_out     (data_out),
        .ctrl_out     (ctrl_out),
        .de_out       (de_out),
        .vld_out      (vld_out),
        .sym_err      (sym_err)
    );

    always #5 clk_pixel = ~clk_pixel;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_lock;
    int       m_run, m_gap, m_skip;
    bit       e_slip, e_err, e_vld, e_de;
    logic [1:0] e_ctrl;
    logic [7:0] e_data;

    function automatic int token_idx(input logic [9:0] s);
        logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
        for (int i = 0; i < 4; i++)
            if (s == toks[i]) return i;
        return -1;
    endfunction

    // Find the byte whose TMDS encoding (with this symbol's mode bits) matches.
    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        for (int b = 0; b < 256; b++) begin
            logic [7:0] byt;
            logic [7:0] q;
            byt  = 8'(b);
            q[0] = byt[0];
            for (int i = 1; i < 8; i++)
                q[i] = s[8] ? (q[i-1] ^ byt[i]) : ~(q[i-1] ^ byt[i]);
            if (s[9]) q = ~q;
            if (q == s[7:0]) return byt;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_run = 0; m_gap = 0; m_skip = 0;
        e_slip = 0; e_err = 0; e_vld = 0; e_de = 0; e_ctrl = '0; e_data = '0;
    endtask

    task automatic model_step(input bit v, input logic [9:0] s);
        int c;
        c = token_idx(s);
        e_slip = 0; e_err = 0; e_vld = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!v) return;
        if (m_lock) begin
            e_vld = 1;
            if (c >= 0) begin e_de = 0; e_ctrl = 2'(c); end
            else begin e_de = 1; e_data = ref_decode(s); end
        end
        if (m_skip > 0) begin
            m_skip--;
        end else if (m_lock) begin
            if (c >= 0) m_gap = 0;
            else if (m_gap == T_OUT - 1) begin
                m_lock = 0; e_slip = 1; e_err = 1;
                m_gap = 0; m_run = 0; m_skip = S_WT;
            end else m_gap++;
        end else begin
            if (c >= 0) begin
                m_gap = 0;
                if (m_run < C_RUN) m_run++;
            end else begin
                m_run = 0;
                m_gap++;
            end
            if (m_run == C_RUN) m_lock = 1;
            else if (m_gap == T_OUT) begin
                e_slip = 1; m_run = 0; m_gap = 0; m_skip = S_WT;
            end
        end
    endtask

    // ---------------- deserializer model ----------------
    int off = 0;
    int n_valid = 0;
    int slips[$];

    function automatic logic [9:0] rot_word(input int o);
        logic [9:0] t;
        logic [9:0] w;
        t = 10'h354;
        for (int j = 0; j < 10; j++) w[j] = t[(j + o) % 10];
        return w;
    endfunction

    // One clock: drive at the falling edge, compare at the next falling edge.
    task automatic drive(input bit v, input logic [9:0] s);
        symbol_valid = v;
        symbol_in    = s;
        model_step(v, s);
        @(posedge clk_pixel);
        @(negedge clk_pixel);
        check(phase, {bitslip, locked, sym_err, vld_out, de_out, ctrl_out, data_out},
                     {e_slip, m_lock, e_err, e_vld, e_de, e_ctrl, e_data});
        if (v && rst_n) n_valid++;
        if (bitslip) slips.push_back(n_valid);
        if (e_slip) off = (off + 9) % 10;
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check({phase, "_async"}, {bitslip, locked, sym_err, vld_out, de_out, ctrl_out, data_out}, 0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        slips.delete();
        n_valid = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk_pixel);

        // Reset held with valid traffic: outputs stay zero.
        phase = "reset_hold";
        for (int i = 0; i < 5; i++) drive(1'b1, 10'($urandom));
        check("reset_outs", {bitslip, locked, sym_err, vld_out, de_out, ctrl_out, data_out}, 0);
        release_reset();

        // First bitslip only after TIMEOUT data symbols.
        phase = "first_timeout";
        for (int i = 0; i < T_OUT; i++) drive(1'b1, 10'h100);
        check("first_slip_cnt", slips.size(), 1);
        if (slips.size() > 0) check("first_slip_at", slips[0], T_OUT);
        for (int i = 0; i < S_WT; i++) drive(1'b1, 10'h100);

        // Broken token runs do not lock; eight in a row do.
        phase = "lock";
        for (int i = 0; i < C_RUN - 1; i++) drive(1'b1, 10'h354);
        drive(1'b1, 10'h100);
        for (int i = 0; i < C_RUN - 1; i++) drive(1'b1, 10'h354);
        check("no_lock_7", locked, 0);
        drive(1'b1, 10'h354);
        check("lock_8", locked, 1);

        // Control and data decode while locked, with valid gaps.
        phase = "decode";
        drive(1'b1, 10'h0AB);
        check("ctrl01", {vld_out, de_out, ctrl_out}, {1'b1, 1'b0, 2'b01});
        drive(1'b1, 10'h100);
        check("dec_100", {vld_out, de_out, data_out}, {1'b1, 1'b1, 8'h00});
        drive(1'b1, 10'h200);
        check("dec_200", {de_out, data_out}, {1'b1, 8'hFF});
        for (int i = 0; i < 3; i++) drive(1'b0, 10'($urandom));
        check("stall_hold", {vld_out, de_out, ctrl_out, data_out}, {1'b0, 1'b1, 2'b01, 8'hFF});
        for (int i = 0; i < 40; i++) drive(1'($urandom_range(0, 1)), 10'($urandom));

        // Lock is held by a token arriving as the 64th symbol, lost on 64 data.
        phase = "loss";
        drive(1'b1, 10'h154);
        for (int i = 0; i < T_OUT - 1; i++) drive(1'b1, 10'h100);
        drive(1'b1, 10'h354);
        check("hold_63", locked, 1);
        for (int i = 0; i < T_OUT; i++) drive(1'b1, 10'h100);
        check("loss_same_cycle", {sym_err, bitslip, locked}, {1'b1, 1'b1, 1'b0});

        // Reset while settling: a full TIMEOUT is needed before the next slip.
        phase = "rst_settle";
        drive(1'b1, 10'h100);
        drive(1'b1, 10'h100);
        assert_reset();
        drive(1'b1, 10'h100);
        release_reset();
        for (int i = 0; i < T_OUT - 1; i++) drive(1'b1, 10'h100);
        check("no_early_slip", slips.size(), 0);
        drive(1'b1, 10'h100);
        check("slip_after_rst", slips.size(), 1);

        // Alignment search from a 3-bit rotated stream.
        phase = "align";
        @(negedge clk_pixel);
        assert_reset();
        drive(1'b0, 10'h000);
        release_reset();
        off = 3;
        for (int k = 0; k < 3000 && !m_lock; k++)
            drive(1'($urandom_range(0, 4) != 0), rot_word(off));
        check("align_locked", locked, 1);
        check("align_slips", slips.size(), 3);
        for (int i = 1; i < slips.size(); i++)
            check("align_spacing", (slips[i] - slips[i-1]) >= (T_OUT + S_WT), 1);

        // Random bursts of tokens and data: loss, slips and relock.
        phase = "random";
        for (int b = 0; b < 120; b++) begin
            int len;
            bit tok;
            logic [9:0] t;
            tok = ($urandom_range(0, 2) == 0);
            len = tok ? $urandom_range(1, 12) : $urandom_range(1, 80);
            t   = 10'(token_idx(10'h354) >= 0 ? 10'h354 : 10'h0);
            case ($urandom_range(0, 3))
                0: t = 10'h354;
                1: t = 10'h0AB;
                2: t = 10'h154;
                default: t = 10'h2AB;
            endcase
            for (int i = 0; i < len; i++)
                drive(1'($urandom_range(0, 3) != 0), tok ? t : 10'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS/DVI video output path. Decodes one TMDS channel.
- Takes 10-bit parallel symbols from an external deserializer in the pixel clock domain.
- Finds word alignment by issuing bitslip pulses until control-token runs are seen.
- Outputs decoded 8-bit pixel data, 2-bit control (sync on blue channel), data-enable and lock status. Three instances plus a shared deserializer form a DVI receiver.

Parameters:
- CTRL_RUN, 8: consecutive valid control tokens required to declare lock.
- TIMEOUT, 2048: consecutive valid symbols without any control token before a bitslip (SEARCH) or loss of lock (LOCKED); counter width is $clog2(TIMEOUT+1).
- SLIP_WAIT, 4: valid symbols ignored after a bitslip while the deserializer settles.

Ports:
- clk_pixel  input  1  pixel clock; all logic is on this clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- symbol_in  input  10  received TMDS symbol; bit 0 was transmitted first.
- symbol_valid  input  1  symbol_in is valid this cycle.
- bitslip  output  1  one-cycle pulse; the deserializer shifts the word boundary by one bit.
- locked  output  1  alignment achieved.
- data_out  output  8  decoded pixel byte.
- ctrl_out  output  2  decoded control bits {C1,C0}.
- de_out  output  1  1 = data symbol, 0 = control symbol.
- vld_out  output  1  data_out/ctrl_out/de_out updated this cycle.
- sym_err  output  1  one-cycle pulse on loss of lock.

Behaviour:
- Reset values: all outputs 0; state SEARCH; all counters 0. Async reset mid-operation clears everything immediately, including a pending bitslip.
- Symbols are processed only when symbol_valid=1. Invalid cycles freeze all counters and state, except the SETTLE counter, which also counts only on valid cycles.
- Control tokens: 0x354 -> ctrl 00; 0x0AB -> 01; 0x154 -> 10; 0x2AB -> 11. Any other symbol is a data symbol.
- Data decode:
  - d = symbol_in[9] ? ~symbol_in[7:0] : symbol_in[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = symbol_in[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Output timing, registered with latency 1 cycle from symbol_valid:
  - vld_out = symbol_valid & locked (the locked value before this symbol's update).
  - On a control symbol: de_out=0, ctrl_out=token bits, data_out holds its previous value.
  - On a data symbol: de_out=1, data_out=decoded byte, ctrl_out holds.
  - When vld_out=0, data_out, ctrl_out and de_out hold their previous values.
- Counters:
  - run_cnt: +1 on each control token, saturates at CTRL_RUN; cleared by any data symbol.
  - gap_cnt: cleared on a control token, +1 on a data symbol.
- State SEARCH:
  - If run_cnt reaches CTRL_RUN, go to LOCKED; locked=1 in the cycle after the CTRL_RUN-th token.
  - Else if gap_cnt reaches TIMEOUT, pulse bitslip for 1 cycle, clear counters, go to SETTLE.
  - If both conditions hit in the same cycle, lock wins.
- State SETTLE: discard SLIP_WAIT valid symbols (no decode, no counting), then go to SEARCH.
- State LOCKED:
  - run_cnt is unused.
  - If gap_cnt reaches TIMEOUT, go to SETTLE: sym_err=1 and bitslip=1 for 1 cycle, locked=0 in the same cycle.
  - gap_cnt must not wrap; it is compared before incrementing.
- bitslip is never asserted in two consecutive cycles. Minimum spacing between pulses is SLIP_WAIT+TIMEOUT valid symbols.

Test Plan:
- Reset: hold rst_n=0 and drive valid symbols -> all outputs stay 0. Release rst_n -> locked=0 and no bitslip until TIMEOUT valid data symbols have passed.
- Aligned lock: 8 consecutive valid 0x354 -> locked=1 one cycle after the 8th. Then 0x0AB -> vld_out=1, de_out=0, ctrl_out=01. A run of 7 tokens, then data, then 7 tokens -> no lock.
- Data decode when locked: 0x100 -> data_out=0x00, de_out=1. 0x200 -> 0xFF. Each result appears exactly 1 cycle after the input; gaps in symbol_valid stall without corruption.
- Alignment search, TIMEOUT=64: bench deserializer model streams the 0x354 bit pattern 3 bits rotated and rotates one bit per bitslip -> exactly 3 bitslip pulses, each 1 cycle, at least 68 valid symbols apart; then locked=1.
- Loss of lock: after lock, drive 64 consecutive data symbols -> sym_err=1, bitslip=1, locked=0 on the same cycle. With 63 data symbols then a 0x354 -> lock is held.
- Reset mid-SETTLE: assert rst_n=0 during SETTLE -> counters clear and state returns to SEARCH; no bitslip is issued after release until a full TIMEOUT has elapsed.
